// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns LFSR mole patterns, times the hit window,
// and hands the round's hit mask to the score counter for exactly one cycle.
module mole_round_ctrl #(
  parameter int                 N_MOLES      = 18,
  parameter int                 CNT_W        = 25,
  parameter int                 ROUND_CYCLES = 25000000,
  parameter int                 GAP_CYCLES   = 5000000,
  parameter int                 NUM_ROUNDS   = 30,
  parameter logic [N_MOLES-1:0] LFSR_SEED    = 18'h2A5F3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_MOLES-1:0] switches,
  output logic [N_MOLES-1:0] led_moles,
  output logic [N_MOLES-1:0] hit_reg,
  output logic               score_en,
  output logic [4:0]         round_num,
  output logic [CNT_W-1:0]   time_left,
  output logic               busy,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_ACTIVE,
    S_SCORE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ROUND_LOAD = CNT_W'(ROUND_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [4:0]       LAST_ROUND = 5'(NUM_ROUNDS);

  state_t             state, next_state;
  logic [N_MOLES-1:0] lfsr, prev_switches, accum;
  logic [N_MOLES-1:0] rise, newhit, spawn_pattern;
  logic [CNT_W-1:0]   timer;
  logic               timer_last;

  logic [N_MOLES-1:0] led_d, hit_d;
  logic [CNT_W-1:0]   time_d;
  logic               score_d, busy_d, over_d;

  assign rise          = switches & ~prev_switches;
  assign newhit        = rise & led_moles;
  assign timer_last    = (timer == ONE);
  assign spawn_pattern = (lfsr == '0) ? N_MOLES'(1) : lfsr;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_SPAWN;
      S_SPAWN:  next_state = S_ACTIVE;
      S_ACTIVE: if (timer_last) next_state = S_SCORE;
      S_SCORE:  next_state = S_GAP;
      S_GAP:    if (timer_last) next_state = (round_num == LAST_ROUND) ? S_DONE : S_SPAWN;
      S_DONE:   if (start) next_state = S_SPAWN;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    led_d  = '0;
    hit_d  = '0;
    time_d = '0;
    unique case (state)
      S_SPAWN: begin
        led_d  = spawn_pattern;
        time_d = ROUND_LOAD;
      end
      S_ACTIVE: begin
        if (timer_last) begin
          hit_d = accum | newhit;
        end else begin
          led_d  = led_moles & ~newhit;
          time_d = timer - ONE;
        end
      end
      default: ;
    endcase
    score_d = (next_state == S_SCORE);
    over_d  = (next_state == S_DONE);
    busy_d  = (next_state == S_SPAWN) || (next_state == S_ACTIVE) ||
              (next_state == S_SCORE) || (next_state == S_GAP);
  end

  // Feedback taps sit at bits 17 and 10 (x^18 + x^11 + 1).
  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr          <= LFSR_SEED;
      prev_switches <= '0;
      accum         <= '0;
      timer         <= '0;
      round_num     <= '0;
    end else begin
      lfsr          <= (lfsr == '0) ? LFSR_SEED : {lfsr[N_MOLES-2:0], lfsr[17] ^ lfsr[10]};
      prev_switches <= switches;
      unique case (state)
        S_IDLE, S_DONE: if (start) round_num <= '0;
        S_SPAWN: begin
          accum <= '0;
          timer <= ROUND_LOAD;
        end
        S_ACTIVE: begin
          accum <= accum | newhit;
          timer <= timer - ONE;
        end
        S_SCORE: begin
          round_num <= round_num + 5'd1;
          timer     <= GAP_LOAD;
        end
        S_GAP:   timer <= timer - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_moles <= '0;
      hit_reg   <= '0;
      score_en  <= 1'b0;
      time_left <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      led_moles <= led_d;
      hit_reg   <= hit_d;
      score_en  <= score_d;
      time_left <= time_d;
      busy      <= busy_d;
      game_over <= over_d;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl: directed and randomized rounds compared
// against a pattern/rise-level model of the round rules.
module tb_mole_round_ctrl;

  localparam int N  = 18;
  localparam int CW = 25;
  localparam int RC = 8;
  localparam int GC = 4;
  localparam int NR = 3;
  localparam logic [N-1:0] SEED = 18'h2A5F3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  switches = '0;

  logic [N-1:0]  led_moles, hit_reg;
  logic          score_en, busy, game_over;
  logic [4:0]    round_num;
  logic [CW-1:0] time_left;

  logic [N-1:0]  led_moles_z, hit_reg_z;
  logic          score_en_z, busy_z, game_over_z;
  logic [4:0]    round_num_z;
  logic [CW-1:0] time_left_z;

  mole_round_ctrl #(.N_MOLES(N), .CNT_W(CW), .ROUND_CYCLES(RC), .GAP_CYCLES(GC),
                    .NUM_ROUNDS(NR), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .switches(switches),
    .led_moles(led_moles), .hit_reg(hit_reg), .score_en(score_en), .round_num(round_num),
    .time_left(time_left), .busy(busy), .game_over(game_over));

  mole_round_ctrl #(.N_MOLES(N), .CNT_W(CW), .ROUND_CYCLES(RC), .GAP_CYCLES(GC),
                    .NUM_ROUNDS(NR), .LFSR_SEED(18'h0)) dut_zero (
    .clk(clk), .reset(reset), .start(start), .switches(switches),
    .led_moles(led_moles_z), .hit_reg(hit_reg_z), .score_en(score_en_z), .round_num(round_num_z),
    .time_left(time_left_z), .busy(busy_z), .game_over(game_over_z));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_score = 0;
  int stray_hit = 0;
  logic [N-1:0] m_lfsr;
  logic [N-1:0] cur_sw = '0;

  // Reference pattern source: the sequence x^18 + x^11 + 1 produces from the seed, one step per clock.
  always @(posedge clk) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= (m_lfsr == '0) ? SEED : {m_lfsr[N-2:0], m_lfsr[17] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    if (score_en) n_score <= n_score + 1;
    if (!score_en && hit_reg != '0) stray_hit <= stray_hit + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},   32'(led_moles), 32'd0);
    check({tag, "_hit"},   32'(hit_reg),   32'd0);
    check({tag, "_score"}, 32'(score_en),  32'd0);
    check({tag, "_round"}, 32'(round_num), 32'd0);
    check({tag, "_time"},  32'(time_left), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_over"},  32'(game_over), 32'd0);
  endtask

  // Entered at the negedge of a SPAWN cycle. mode: 0 idle switches, 1 hold+last-cycle hit,
  // 2 unlit rise + toggling, 3 random, 4 hit then reset at ACTIVE cycle abort_at.
  task automatic play_round(input int r, input int mode, input int abort_at);
    logic [N-1:0] pat, hits, a, b, u, rest, nsw, rise;
    pat  = (m_lfsr == '0) ? 18'h00001 : m_lfsr;
    a    = pat & (~pat + 18'd1);
    rest = pat & ~a;
    b    = (rest == '0) ? a : (rest & (~rest + 18'd1));
    u    = ~pat & (pat + 18'd1);
    hits = '0;
    check("spawn_round_num", 32'(round_num), 32'(r - 1));
    check("spawn_busy",      32'(busy),      32'd1);
    check("spawn_game_over", 32'(game_over), 32'd0);
    start = 1'($urandom_range(0, 1));
    for (int j = 0; j < RC; j++) begin
      step();
      check("active_led",       32'(led_moles), 32'(pat & ~hits));
      check("active_time_left", 32'(time_left), 32'(RC - j));
      check("active_hit_reg",   32'(hit_reg),   32'd0);
      if (j == 0) check("zero_seed_led", 32'(led_moles_z), 32'd1);
      case (mode)
        1:       nsw = ((j >= 2) ? a : 18'h0) | ((j == RC - 1) ? b : 18'h0);
        2:       nsw = ((j >= 1) ? u : 18'h0) | ((j == 2 || j == 4 || j == 6) ? a : 18'h0);
        3:       nsw = cur_sw ^ 18'($urandom & $urandom & $urandom);
        4:       nsw = a;
        default: nsw = '0;
      endcase
      switches = nsw;
      start    = 1'($urandom_range(0, 1));
      rise     = nsw & ~cur_sw;
      cur_sw   = nsw;
      hits     = hits | (rise & pat);
      if (j == abort_at) begin
        reset = 1'b0;
        step();
        check_all_zero("abort");
        reset = 1'b1;
        start = 1'b0;
        return;
      end
    end
    step();
    check("score_en",        32'(score_en),  32'd1);
    check("score_hit_reg",   32'(hit_reg),   32'(hits));
    check("score_led",       32'(led_moles), 32'd0);
    check("score_time_left", 32'(time_left), 32'd0);
    check("score_round_num", 32'(round_num), 32'(r - 1));
    if (mode == 1) check("directed_hold_last",    32'(hit_reg), 32'(a | b));
    if (mode == 2) check("directed_unlit_toggle", 32'(hit_reg), 32'(a));
    for (int g = 0; g < GC; g++) begin
      nsw      = (mode == 3) ? (cur_sw ^ 18'($urandom & $urandom)) : 18'h0;
      switches = nsw;
      cur_sw   = nsw;
      start    = 1'($urandom_range(0, 1));
      step();
      check("gap_led",       32'(led_moles), 32'd0);
      check("gap_score",     32'(score_en),  32'd0);
      check("gap_time_left", 32'(time_left), 32'd0);
      check("gap_round_num", 32'(round_num), 32'(r));
      check("gap_busy",      32'(busy),      32'd1);
    end
  endtask

  task automatic check_done();
    start = 1'b0;
    check("done_game_over", 32'(game_over), 32'd1);
    check("done_round_num", 32'(round_num), 32'(NR));
    check("done_busy",      32'(busy),      32'd0);
    check("done_led",       32'(led_moles), 32'd0);
  endtask

  initial begin
    step();
    step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Game 1: quiet round, then the two directed hit scenarios.
    start = 1'b1;
    step();
    play_round(1, 0, -1);
    step();
    play_round(2, 1, -1);
    step();
    play_round(3, 2, -1);
    step();
    check_done();
    for (int k = 0; k < 3; k++) begin
      step();
      check("done_hold_over",  32'(game_over), 32'd1);
      check("done_hold_round", 32'(round_num), 32'(NR));
    end

    // Game 2: restart from DONE, one random round, then reset mid-ACTIVE.
    start = 1'b1;
    step();
    play_round(1, 3, -1);
    step();
    play_round(2, 4, 3);
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_abort_busy",  32'(busy),      32'd0);
      check("post_abort_over",  32'(game_over), 32'd0);
      check("post_abort_score", 32'(score_en),  32'd0);
    end

    // Game 3: full randomized game from IDLE.
    start = 1'b1;
    step();
    for (int r = 1; r <= NR; r++) begin
      play_round(r, 3, -1);
      step();
    end
    check_done();
    step();
    step();
    check("score_pulse_count", 32'(n_score),   32'd7);
    check("stray_hit_cycles",  32'(stray_hit), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
